// File: rtl/vx_mem_perf_collector.sv
// Passive memory-bus perf collector: counts accepted reads/writes and integrates outstanding reads.
// Define MEM_PERF_MAX_LAT_EN to add per-tag timestamps and a worst-case read latency tracker.
module vx_mem_perf_collector #(
  parameter int unsigned CTR_BITS    = 44,
  parameter int unsigned TAG_WIDTH   = 4,
  parameter int unsigned MAX_PENDING = 64,
  parameter int unsigned LAT_BITS    = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               clear,
  input  logic                               mem_req_valid,
  input  logic                               mem_req_ready,
  input  logic                               mem_req_rw,
  input  logic [TAG_WIDTH-1:0]               mem_req_tag,
  input  logic                               mem_rsp_valid,
  input  logic                               mem_rsp_ready,
  input  logic [TAG_WIDTH-1:0]               mem_rsp_tag,
  output logic [CTR_BITS-1:0]                mem_reads,
  output logic [CTR_BITS-1:0]                mem_writes,
  output logic [CTR_BITS-1:0]                mem_latency,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending_reads,
  output logic                               err,
  output logic [LAT_BITS-1:0]                max_latency
);

  localparam int unsigned PendBits = $clog2(MAX_PENDING + 1);
  localparam logic [PendBits-1:0] PendMax = PendBits'(MAX_PENDING);

  logic req_fire, rd_fire, wr_fire, rsp_fire;

  logic [CTR_BITS-1:0] reads_q, reads_d;
  logic [CTR_BITS-1:0] writes_q, writes_d;
  logic [CTR_BITS-1:0] lat_q, lat_d;
  logic [CTR_BITS:0]   lat_sum;
  logic [PendBits-1:0] pend_q, pend_d;
  logic                err_q, err_d;

  assign req_fire = mem_req_valid & mem_req_ready;
  assign rd_fire  = req_fire & ~mem_req_rw;
  assign wr_fire  = req_fire & mem_req_rw;
  assign rsp_fire = mem_rsp_valid & mem_rsp_ready;

  // Extra carry bit detects saturation of the latency integrator.
  assign lat_sum = {1'b0, lat_q} + (CTR_BITS + 1)'(pend_q);

  always_comb begin
    reads_d  = reads_q;
    writes_d = writes_q;
    lat_d    = lat_q;
    pend_d   = pend_q;
    err_d    = err_q;

    // Pending tracker follows the bus even while counters are being cleared.
    if (rd_fire && !rsp_fire) begin
      if (pend_q == PendMax) begin
        err_d = 1'b1;
      end else begin
        pend_d = pend_q + PendBits'(1);
      end
    end else if (rsp_fire && !rd_fire) begin
      if (pend_q == '0) begin
        err_d = 1'b1;
      end else begin
        pend_d = pend_q - PendBits'(1);
      end
    end

    if (clear) begin
      reads_d  = CTR_BITS'(rd_fire);
      writes_d = CTR_BITS'(wr_fire);
      lat_d    = '0;
      err_d    = 1'b0;
    end else begin
      if (rd_fire && (reads_q != '1)) begin
        reads_d = reads_q + CTR_BITS'(1);
      end
      if (wr_fire && (writes_q != '1)) begin
        writes_d = writes_q + CTR_BITS'(1);
      end
      lat_d = lat_sum[CTR_BITS] ? '1 : lat_sum[CTR_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reads_q  <= '0;
      writes_q <= '0;
      lat_q    <= '0;
      pend_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      reads_q  <= reads_d;
      writes_q <= writes_d;
      lat_q    <= lat_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
    end
  end

  assign mem_reads     = reads_q;
  assign mem_writes    = writes_q;
  assign mem_latency   = lat_q;
  assign pending_reads = pend_q;
  assign err           = err_q;

`ifdef MEM_PERF_MAX_LAT_EN
  localparam int unsigned NumTags = 1 << TAG_WIDTH;

  logic [LAT_BITS-1:0] now_q;
  logic [LAT_BITS-1:0] stamp_q [NumTags];
  logic [LAT_BITS-1:0] max_q, max_d;
  logic [LAT_BITS-1:0] rsp_lat;

  // Reads the old stamp, so a same-cycle read reusing the tag cannot corrupt it.
  assign rsp_lat = now_q - stamp_q[mem_rsp_tag];

  always_comb begin
    max_d = max_q;
    if (clear) begin
      max_d = '0;
    end else if (rsp_fire && (rsp_lat > max_q)) begin
      max_d = rsp_lat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      now_q <= '0;
      max_q <= '0;
      for (int i = 0; i < NumTags; i++) begin
        stamp_q[i] <= '0;
      end
    end else begin
      now_q <= now_q + LAT_BITS'(1);
      max_q <= max_d;
      if (rd_fire) begin
        stamp_q[mem_req_tag] <= now_q;
      end
    end
  end

  assign max_latency = max_q;
`else
  logic unused_tags;

  assign unused_tags = ^{mem_req_tag, mem_rsp_tag};
  assign max_latency = '0;
`endif

endmodule
